// File: rtl/lcd_image_scan.sv
// LCD raster scanner with image-ROM address generation and output pixel formatting.
// A free-running x/y raster drives a registered ROM address for every on-screen image
// pixel. The returned RGB565 word is merged with sync/DE flags that have been delayed to
// match the ROM latency, so every pin carries the same ROM_LAT+2 clock latency.
module lcd_image_scan #(
    parameter int          H_ACTIVE   = 480,
    parameter int          H_FP       = 8,
    parameter int          H_SYNC     = 4,
    parameter int          H_BP       = 43,
    parameter int          V_ACTIVE   = 272,
    parameter int          V_FP       = 8,
    parameter int          V_SYNC     = 4,
    parameter int          V_BP       = 12,
    parameter int          IMG_W      = 64,
    parameter int          IMG_H      = 32,
    parameter int          IMG_X      = 176,
    parameter int          IMG_Y      = 104,
    parameter int          SCALE_LOG2 = 1,
    parameter int          ROM_LAT    = 2,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] ad,
    input  logic [15:0] data,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic [4:0]  r,
    output logic [5:0]  g,
    output logic [4:0]  b,
    output logic        frame
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW        = $clog2(H_TOTAL);
    localparam int YW        = $clog2(V_TOTAL);
    localparam int HS_BEG    = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_BEG + H_SYNC;
    localparam int VS_BEG    = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_BEG + V_SYNC;
    localparam int IMG_X_END = IMG_X + (IMG_W << SCALE_LOG2);
    localparam int IMG_Y_END = IMG_Y + (IMG_H << SCALE_LOG2);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    // The address bus is 11 bits, the bank decode relies on IMG_W being a power of two,
    // and the flag delay line needs at least one stage.
    generate
        if (IMG_W * IMG_H > 2048) begin : g_bad_size
            $error("lcd_image_scan: IMG_W*IMG_H exceeds the 2048-word ROM");
        end
        if ((IMG_W < 1) || ((IMG_W & (IMG_W - 1)) != 0)) begin : g_bad_width
            $error("lcd_image_scan: IMG_W must be a power of two");
        end
        if (ROM_LAT < 1) begin : g_bad_lat
            $error("lcd_image_scan: ROM_LAT must be at least 1");
        end
    endgenerate

    // Per-pixel timing flags that travel alongside the ROM request.
    typedef struct packed {
        logic vld;   // visible pixel (becomes de)
        logic hs;    // inside horizontal sync pulse
        logic vs;    // inside vertical sync pulse
        logic img;   // visible pixel covered by the image window
        logic sof;   // pixel (0,0), start of frame
    } flags_t;

    // Picks the pin colour: ROM word inside the image, background elsewhere on screen,
    // black during blanking.
    function automatic logic [15:0] fmt_pixel(input flags_t f, input logic [15:0] word);
        if (f.img) begin
            return word;
        end else if (f.vld) begin
            return BG_COLOR;
        end else begin
            return 16'h0000;
        end
    endfunction

    // ---------------- stage 0: raster counters ----------------
    logic [XW-1:0] x_p0;
    logic [YW-1:0] y_p0;
    int            x_i;
    int            y_i;
    int            col_p0;
    int            row_p0;
    flags_t        flags_p0;
    logic [10:0]   addr_p0;

    // x sweeps the whole line, y advances on each x wrap; both restart at (0,0) on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else if (x_p0 == X_LAST) begin
            x_p0 <= '0;
            y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + YW'(1);
        end else begin
            x_p0 <= x_p0 + XW'(1);
        end
    end

    // Decode the current raster position into flags and the image word it maps to.
    always_comb begin
        x_i          = int'(x_p0);
        y_i          = int'(y_p0);
        flags_p0     = '0;
        flags_p0.vld = (x_i < H_ACTIVE) && (y_i < V_ACTIVE);
        flags_p0.hs  = (x_i >= HS_BEG) && (x_i < HS_END);
        flags_p0.vs  = (y_i >= VS_BEG) && (y_i < VS_END);
        flags_p0.sof = (x_i == 0) && (y_i == 0);
        // Requiring vld clips the image at the right and bottom screen edges.
        flags_p0.img = flags_p0.vld &&
                       (x_i >= IMG_X) && (x_i < IMG_X_END) &&
                       (y_i >= IMG_Y) && (y_i < IMG_Y_END);
        // Shifting the window offset implements the 2^S pixel/line replication.
        col_p0       = (x_i - IMG_X) >>> SCALE_LOG2;
        row_p0       = (y_i - IMG_Y) >>> SCALE_LOG2;
        addr_p0      = 11'(row_p0 * IMG_W + col_p0);
    end

    // ---------------- stage 1: ROM address register ----------------
    flags_t flags_p1;

    // ad only moves on image pixels. Outside the window it holds, so the combinational
    // bank select on ad[10] stays put while the last image words are still in the ROM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ad       <= '0;
            flags_p1 <= '0;
        end else begin
            flags_p1 <= flags_p0;
            if (flags_p0.img) begin
                ad <= addr_p0;
            end
        end
    end

    // ---------------- stage 2: flag delay matching the ROM latency ----------------
    flags_t flags_p2 [ROM_LAT];

    // Shift the flags ROM_LAT clocks so they line up with the word the ROM returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                flags_p2[i] <= '0;
            end
        end else begin
            flags_p2[0] <= flags_p1;
            for (int i = 1; i < ROM_LAT; i++) begin
                flags_p2[i] <= flags_p2[i-1];
            end
        end
    end

    // ---------------- stage 3: output registers ----------------
    logic [15:0] rgb_p3;

    // Register the pins together so sync, DE, frame and colour share one latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            de      <= 1'b0;
            frame   <= 1'b0;
            rgb_p3  <= 16'h0000;
        end else begin
            hsync_n <= ~flags_p2[ROM_LAT-1].hs;
            vsync_n <= ~flags_p2[ROM_LAT-1].vs;
            de      <= flags_p2[ROM_LAT-1].vld;
            frame   <= flags_p2[ROM_LAT-1].sof;
            rgb_p3  <= fmt_pixel(flags_p2[ROM_LAT-1], data);
        end
    end

    assign r = rgb_p3[15:11];
    assign g = rgb_p3[10:5];
    assign b = rgb_p3[4:0];

endmodule

// File: tb/tb_lcd_image_scan.sv
// Bench for lcd_image_scan: three instances (small window, 2x scaled full screen, large
// two-bank image with clipping) compared every cycle against a raster model, plus
// directed literal expectations at hand-picked raster positions.
module tb_lcd_image_scan;

    typedef struct {
        int          ha, hfp, hsy, hbp;
        int          va, vfp, vsy, vbp;
        int          iw, ih, ix, iy, s;
        logic [15:0] bg;
        int          rom_kind;   // 0: ROM returns its address, 1: golden two-bank image
    } cfg_t;

    localparam int PIPE = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cfg_t cfg_a, cfg_b, cfg_c;
    int   k;
    int   checks = 0;
    int   errors = 0;
    int   last_a, last_b, last_c;
    logic prev_c10;
    int   hcnt = 0, vcnt = 0;
    int   rgb_tab [8] = '{0, 0, 0, 1, 2, 3, 0, 0};
    int   adb_tab [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    logic [10:0] ad_a, ad_b, ad_c;
    logic [15:0] data_a, data_b, data_c;
    logic        hsync_n_a, vsync_n_a, de_a, frame_a;
    logic        hsync_n_b, vsync_n_b, de_b, frame_b;
    logic        hsync_n_c, vsync_n_c, de_c, frame_c;
    logic [4:0]  r_a, b_a, r_b, b_b, r_c, b_c;
    logic [5:0]  g_a, g_b, g_c;
    logic [15:0] rgb_a, rgb_b, rgb_c;
    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};
    assign rgb_c = {r_c, g_c, b_c};

    lcd_image_scan #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .IMG_W(4), .IMG_H(2), .IMG_X(2), .IMG_Y(1),
                     .SCALE_LOG2(0), .ROM_LAT(2), .BG_COLOR(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .ad(ad_a), .data(data_a), .hsync_n(hsync_n_a),
        .vsync_n(vsync_n_a), .de(de_a), .r(r_a), .g(g_a), .b(b_a), .frame(frame_a));

    lcd_image_scan #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .IMG_W(4), .IMG_H(2), .IMG_X(0), .IMG_Y(0),
                     .SCALE_LOG2(1), .ROM_LAT(2), .BG_COLOR(16'h0000)) dut_b (
        .clk(clk), .reset(reset), .ad(ad_b), .data(data_b), .hsync_n(hsync_n_b),
        .vsync_n(vsync_n_b), .de(de_b), .r(r_b), .g(g_b), .b(b_b), .frame(frame_b));

    lcd_image_scan #(.H_ACTIVE(72), .H_FP(2), .H_SYNC(2), .H_BP(4),
                     .V_ACTIVE(34), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .IMG_W(64), .IMG_H(32), .IMG_X(16), .IMG_Y(8),
                     .SCALE_LOG2(0), .ROM_LAT(2), .BG_COLOR(16'hBEEF)) dut_c (
        .clk(clk), .reset(reset), .ad(ad_c), .data(data_c), .hsync_n(hsync_n_c),
        .vsync_n(vsync_n_c), .de(de_c), .r(r_c), .g(g_c), .b(b_c), .frame(frame_c));

    // Golden image word for ROM address a; the upper bank is visibly different.
    function automatic logic [15:0] gold(input int a);
        logic [15:0] v;
        v = 16'(a * 37 + 'h1234);
        if (a >= 1024) v = v ^ 16'hF00F;
        return v;
    endfunction

    function automatic logic [15:0] rom_val(input cfg_t c, input int a);
        return (c.rom_kind == 0) ? 16'(a) : gold(a);
    endfunction

    // ROM models: two-clock pipelined read. The large ROM muxes its banks on the live ad[10].
    logic [10:0] rom_a_p0, rom_a_p1, rom_b_p0, rom_b_p1;
    logic [9:0]  rom_c_p0, rom_c_p1;
    always @(posedge clk) begin
        rom_a_p0 <= ad_a;       rom_a_p1 <= rom_a_p0;
        rom_b_p0 <= ad_b;       rom_b_p1 <= rom_b_p0;
        rom_c_p0 <= ad_c[9:0];  rom_c_p1 <= rom_c_p0;
    end
    assign data_a = {5'd0, rom_a_p1};
    assign data_b = {5'd0, rom_b_p1};
    assign data_c = gold(int'({ad_c[10], rom_c_p1}));

    // Clocks elapsed since reset release; the counters sit at raster index k.
    always @(posedge clk) k <= reset ? 0 : k + 1;

    // What the raster rules say about linear pixel index m of a frame sequence.
    function automatic void pix(input cfg_t c, input int m, output bit act, output bit hs,
                                output bit vs, output bit img, output bit sof, output int addr);
        int ht, vt, x, y;
        ht   = c.ha + c.hfp + c.hsy + c.hbp;
        vt   = c.va + c.vfp + c.vsy + c.vbp;
        x    = m % ht;
        y    = (m / ht) % vt;
        act  = (x < c.ha) && (y < c.va);
        hs   = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hsy);
        vs   = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vsy);
        sof  = (x == 0) && (y == 0);
        img  = act && (x >= c.ix) && (x < c.ix + (c.iw << c.s)) &&
                      (y >= c.iy) && (y < c.iy + (c.ih << c.s));
        addr = ((y - c.iy) >> c.s) * c.iw + ((x - c.ix) >> c.s);
    endfunction

    task automatic check_inst(input string nm, input cfg_t c, input int kk, input logic rst_now,
                              input logic [10:0] ad_v, input logic hs_n, input logic vs_n,
                              input logic de_v, input logic fr_v, input logic [15:0] rgb_v,
                              inout int last);
        bit act, hs, vs, img, sof;
        int addr;
        logic [19:0] exp_pins, act_pins;
        logic [15:0] ergb;
        exp_pins = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        if (rst_now) begin
            last = 0;
        end else begin
            if (kk >= 1) begin
                pix(c, kk - 1, act, hs, vs, img, sof, addr);
                if (img) last = addr;
            end
            if (kk >= PIPE) begin
                pix(c, kk - PIPE, act, hs, vs, img, sof, addr);
                ergb = img ? rom_val(c, addr) : (act ? c.bg : 16'h0000);
                exp_pins = {~hs, ~vs, act, sof, ergb};
            end
        end
        act_pins = {hs_n, vs_n, de_v, fr_v, rgb_v};
        checks++;
        if (act_pins !== exp_pins) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s_pins k=%0d got {hs_n,vs_n,de,frame,rgb}=%h want %h",
                         nm, kk, act_pins, exp_pins);
        end
        checks++;
        if (ad_v !== 11'(last)) begin
            errors++;
            if (errors < 40) $display("FAIL %s_ad k=%0d got %0d want %0d", nm, kk, ad_v, last);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        bit act, hs, vs, img, sof;
        int addr;
        check_inst("a", cfg_a, k, reset, ad_a, hsync_n_a, vsync_n_a, de_a, frame_a, rgb_a, last_a);
        check_inst("b", cfg_b, k, reset, ad_b, hsync_n_b, vsync_n_b, de_b, frame_b, rgb_b, last_b);
        check_inst("c", cfg_c, k, reset, ad_c, hsync_n_c, vsync_n_c, de_c, frame_c, rgb_c, last_c);
        if (!reset && k >= 1 && ad_c[10] !== prev_c10) begin
            pix(cfg_c, k - 1, act, hs, vs, img, sof, addr);
            checks++;
            if (!img) begin
                errors++;
                $display("FAIL c_bank_toggle k=%0d got in_img=0 want 1", k);
            end
        end
        prev_c10 = ad_c[10];
    end

    task automatic expect_v(input string nm, input int kk, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s k=%0d got %0h want %0h", nm, kk, got, want);
        end
    endtask

    // Hand-computed expectations for the first run after reset release.
    task automatic lit1(input int kk);
        if (kk <= 3) expect_v("pre_de_frame", kk, int'({de_a, frame_a}), 0);
        if (kk == 4) begin
            expect_v("first_de", kk, int'(de_a), 1);
            expect_v("first_frame", kk, int'(frame_a), 1);
        end
        if (kk == 5) expect_v("frame_one_clock", kk, int'(frame_a), 0);
        if (kk >= 1 && kk <= 8) expect_v("b_ad_scaled", kk, int'(ad_b), adb_tab[kk-1]);
        if (kk == 13) expect_v("b_row_repeat", kk, int'(ad_b), 0);
        if (kk == 15) expect_v("b_row_repeat", kk, int'(ad_b), 1);
        if (kk == 25 || kk == 26) expect_v("b_row1", kk, int'(ad_b), 4);
        if (kk == 27) expect_v("b_row1", kk, int'(ad_b), 5);
        if (kk == 6) expect_v("b_rgb", kk, int'(rgb_b), 1);
        if (kk == 29) expect_v("b_rgb", kk, int'(rgb_b), 4);
        if (kk >= 16 && kk <= 23) expect_v("a_rgb_y1", kk, int'(rgb_a), rgb_tab[kk-16]);
        if (kk >= 18 && kk <= 26) expect_v("a_ad_hold", kk, int'(ad_a), 3);
        if (kk >= 27 && kk <= 30) expect_v("a_ad_y2", kk, int'(ad_a), kk - 23);
        if (kk >= 4 && kk < 88) begin
            if (!hsync_n_a) hcnt++;
            if (!vsync_n_a) vcnt++;
        end
        if (kk == 87) expect_v("frame_gap", kk, int'(frame_a), 0);
        if (kk == 88) begin
            expect_v("frame_period", kk, int'(frame_a), 1);
            expect_v("hsync_low_per_frame", kk, hcnt, 7);
            expect_v("vsync_low_per_frame", kk, vcnt, 12);
        end
        if (kk == 112) begin
            expect_v("pre_reset_de", kk, int'(de_a), 1);
            expect_v("pre_reset_ad", kk, int'(ad_a), 5);
        end
    endtask

    // Hand-computed expectations after the mid-line reset, mainly the two-bank image.
    task automatic lit2(input int kk);
        if (kk == 3) expect_v("restart_frame_early", kk, int'(frame_a), 0);
        if (kk == 4) begin
            expect_v("restart_frame", kk, int'(frame_a), 1);
            expect_v("c_frame", kk, int'(frame_c), 1);
            expect_v("c_bg", kk, int'(rgb_c), 'hBEEF);
        end
        if (kk == 1860) expect_v("c_row15_col0", kk, int'(rgb_c), 'h9CF4);
        if (kk == 1915) expect_v("c_row15_clip", kk, int'(rgb_c), 'hA4E7);
        if (kk == 1916) expect_v("c_blank", kk, int'(rgb_c), 0);
        if (kk == 1936) expect_v("c_ad_hold", kk, int'(ad_c), 1015);
        if (kk == 1937) expect_v("c_ad_row16", kk, int'(ad_c), 1024);
        if (kk == 1940) expect_v("c_row16_col0", kk, int'(rgb_c), 'h563B);
        if (kk == 1941) expect_v("c_row16_col1", kk, int'(rgb_c), 'h5656);
        if (kk == 2964) expect_v("c_frame_period", kk, int'(frame_c), 1);
    endtask

    initial begin
        cfg_a = '{ha:8, hfp:1, hsy:1, hbp:2, va:4, vfp:1, vsy:1, vbp:1,
                  iw:4, ih:2, ix:2, iy:1, s:0, bg:16'h0000, rom_kind:0};
        cfg_b = '{ha:8, hfp:1, hsy:1, hbp:2, va:4, vfp:1, vsy:1, vbp:1,
                  iw:4, ih:2, ix:0, iy:0, s:1, bg:16'h0000, rom_kind:0};
        cfg_c = '{ha:72, hfp:2, hsy:2, hbp:4, va:34, vfp:1, vsy:1, vbp:1,
                  iw:64, ih:32, ix:16, iy:8, s:0, bg:16'hBEEF, rom_kind:1};
        last_a = 0; last_b = 0; last_c = 0; prev_c10 = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lit1(k);
            if (k == 112) break;
        end
        expect_v("reach_reset_point", k, k, 112);

        // Counters now advance to x=5, y=2; hit reset for one clock there.
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        expect_v("rst_de", k, int'(de_a), 0);
        expect_v("rst_hsync_n", k, int'(hsync_n_a), 1);
        expect_v("rst_vsync_n", k, int'(vsync_n_a), 1);
        expect_v("rst_rgb", k, int'(rgb_a), 0);
        expect_v("rst_frame", k, int'(frame_a), 0);
        expect_v("rst_ad", k, int'(ad_a), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            lit2(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
